// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO read-side drain/packer.
package fifo_drain_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned PACK_DEF       = 2;

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Lane-keep mask with the low cnt lanes set (cnt up to 8).
  function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
    return 8'((9'(1) << cnt) - 9'(1));
  endfunction

endpackage

// File: rtl/fifo_drain_obuf.sv
// Single-beat output holding slot on a valid/ready stream.
module fifo_drain_obuf #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned KEEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic [BEAT_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              slot_free_c
);

  assign slot_free_c = !m_valid || m_ready;

  // Payload only changes on load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_drain_packer.sv
// Drains a registered-read FIFO, packs PACK words per beat and supports
// flushing a partial beat with a lane-keep mask.
module fifo_drain_packer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned PACK       = PACK_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]      fifo_data_out,
  input  logic                       fifo_empty,
  input  logic                       fifo_underflow,
  output logic [FIFO_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       busy,
  output logic [7:0]                 err_cnt
);

  localparam int unsigned CNT_W  = $clog2(PACK + 1);
  localparam int unsigned IDX_W  = $clog2(PACK);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned BEAT_W = FIFO_WIDTH * PACK;

  state_t                         state, state_n;
  logic [PACK-1:0][FIFO_WIDTH-1:0] asm_data, asm_data_n, load_data;
  logic [CNT_W-1:0]               asm_cnt, asm_cnt_n;
  logic                           rd_pend;
  logic                           slot_free_c;
  logic                           load, load_last, done_n, busy_n, flush_ok;
  logic [PACK-1:0]                load_keep, part_keep;

  // Next-state, assembly update and slot-load decisions.
  always_comb begin
    state_n    = state;
    asm_data_n = asm_data;
    asm_cnt_n  = asm_cnt;
    load       = 1'b0;
    load_last  = 1'b0;
    load_keep  = '1;
    load_data  = '0;
    done_n     = 1'b0;
    part_keep  = PACK'(keep_mask(4'(asm_cnt)));
    fifo_rd_en = !rst && (state == ST_PACK) && !fifo_empty &&
                 ((SUM_W'(asm_cnt) + SUM_W'(rd_pend)) < SUM_W'(PACK));
    // Nothing in flight and nothing being read: a flush can resolve now.
    flush_ok   = !rd_pend && !fifo_rd_en && slot_free_c;

    if (rd_pend) begin
      asm_data_n[IDX_W'(asm_cnt)] = fifo_data_out;
      asm_cnt_n = CNT_W'(asm_cnt + CNT_W'(1));
    end

    case (state)
      ST_PACK: begin
        if (flush && flush_ok && (asm_cnt != CNT_W'(PACK))) begin
          if (asm_cnt == '0) begin
            done_n = 1'b1;
          end else begin
            load      = 1'b1;
            load_last = 1'b1;
            load_keep = part_keep;
            asm_cnt_n = '0;
            state_n   = ST_EMIT;
          end
        end else begin
          if ((asm_cnt == CNT_W'(PACK)) && slot_free_c) begin
            load      = 1'b1;
            asm_cnt_n = '0;
          end
          if (flush) state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!rd_pend && slot_free_c) begin
          if (asm_cnt == '0) begin
            done_n  = 1'b1;
            state_n = ST_PACK;
          end else begin
            load      = 1'b1;
            load_last = 1'b1;
            load_keep = part_keep;
            asm_cnt_n = '0;
            state_n   = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (m_valid && m_ready) begin
          done_n  = 1'b1;
          state_n = ST_PACK;
        end
      end
      default: state_n = ST_PACK;
    endcase

    for (int i = 0; i < int'(PACK); i++) begin
      load_data[i] = load_keep[i] ? asm_data[i] : '0;
    end

    busy_n = fifo_rd_en || (asm_cnt_n != '0) || load ||
             (m_valid && !m_ready) || (state_n != ST_PACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_PACK;
      asm_data   <= '0;
      asm_cnt    <= '0;
      rd_pend    <= 1'b0;
      flush_done <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      asm_data   <= asm_data_n;
      asm_cnt    <= asm_cnt_n;
      rd_pend    <= fifo_rd_en;
      flush_done <= done_n;
      busy       <= busy_n;
      if (fifo_underflow && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  fifo_drain_obuf #(
    .BEAT_W(BEAT_W),
    .KEEP_W(PACK)
  ) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (load_data),
    .load_keep   (load_keep),
    .load_last   (load_last),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .slot_free_c (slot_free_c)
  );

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a word-stream scoreboard.
module tb_fifo_drain_packer;

  localparam int unsigned W    = 16;
  localparam int unsigned PACK = 2;
  localparam int unsigned BW   = W * PACK;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [BW-1:0] m_data;
  logic [PACK-1:0] m_keep;
  logic          m_valid, m_ready, m_last;
  logic          flush, flush_done, busy;
  logic [7:0]    err_cnt;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mem [0:63];
  logic [5:0]   wr_ptr = '0;
  logic [5:0]   rd_ptr = '0;

  logic [W-1:0]    words_q[$];
  logic [BW+PACK:0] beat_log[$];
  int flush_issued = 0;
  int flush_served = 0;

  fifo_drain_packer #(.FIFO_WIDTH(W), .PACK(PACK)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .m_data(m_data),
    .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .flush(flush), .flush_done(flush_done), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Registered-read FIFO model.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= wr_ptr;
      fifo_data_out <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 6'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: beats must repack the words read, in order; flush emits the remainder.
  initial begin : compare
    logic          prev_valid, prev_ready, prev_last, prev_last_acc, exp_last, pend;
    logic [PACK-1:0] prev_keep, exp_keep;
    logic [BW-1:0] prev_data, exp_data;
    int n;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_last_acc = 0;
    prev_keep = '0; prev_data = '0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        words_q.delete();
        flush_served  = flush_issued;
        prev_valid    = 0;
        prev_ready    = 0;
        prev_last_acc = 0;
      end else begin
        if (prev_last_acc) check("flush_done_after_last", flush_done, 1);
        else if (flush_done)
          check("flush_done_empty", (flush_issued > flush_served) && (words_q.size() == 0), 1);
        if (flush_done) flush_served = flush_issued;
        if (fifo_rd_en) begin
          check("rd_on_empty", fifo_empty, 0);
          words_q.push_back(mem[rd_ptr]);
        end
        if (prev_valid && !prev_ready)
          check("hold", {m_valid, m_last, m_keep, m_data}, {1'b1, prev_last, prev_keep, prev_data});
        prev_last_acc = 0;
        if (m_valid && m_ready) begin
          pend     = flush_issued > flush_served;
          exp_last = pend && (words_q.size() < PACK);
          n        = exp_last ? words_q.size() : PACK;
          check("beat_words_avail", (words_q.size() >= n) && (n > 0), 1);
          exp_data = '0;
          for (int i = 0; i < int'(PACK); i++)
            if (i < n && words_q.size() > 0) exp_data[i*W +: W] = words_q.pop_front();
          exp_keep = PACK'((1 << n) - 1);
          check("beat", {m_last, m_keep, m_data}, {exp_last, exp_keep, exp_data});
          beat_log.push_back({m_last, m_keep, m_data});
          prev_last_acc = exp_last;
        end
        prev_valid = m_valid; prev_ready = m_ready; prev_last = m_last;
        prev_keep  = m_keep;  prev_data  = m_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    flush_issued++;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n);
    int k = 0;
    while (beat_log.size() < n && k < 200) begin tick(1); k++; end
    check(name, beat_log.size() >= n, 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || !fifo_empty) && k < 200) begin tick(1); k++; end
    check(name, busy, 0);
  endtask

  initial begin : stim
    int cnt_a, cnt_b;
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0; fifo_underflow = 1'b0;
    tick(3);
    check("reset_outputs", {fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done, busy, err_cnt},
          '0);
    rst = 1'b0;
    tick(2);

    // Streaming
    m_ready = 1'b1;
    beat_log.delete();
    for (int i = 1; i <= 8; i++) push(W'(i));
    wait_beats("stream_timeout", 4);
    check("stream_b0", beat_log[0], {1'b0, 2'b11, 32'h00020001});
    check("stream_b1", beat_log[1], {1'b0, 2'b11, 32'h00040003});
    check("stream_b2", beat_log[2], {1'b0, 2'b11, 32'h00060005});
    check("stream_b3", beat_log[3], {1'b0, 2'b11, 32'h00080007});
    wait_idle("stream_idle");

    // Back-pressure
    m_ready = 1'b0;
    beat_log.delete();
    for (int i = 'hA; i <= 'hF; i++) push(W'(i));
    cnt_a = 0;
    repeat (20) begin #1; if (fifo_rd_en) cnt_a++; tick(1); end
    check("bp_reads", cnt_a, 4);
    check("bp_slot", {m_valid, m_data}, {1'b1, 32'h000B000A});
    check("bp_no_accept", beat_log.size(), 0);
    m_ready = 1'b1;
    wait_beats("bp_timeout", 3);
    check("bp_b0", beat_log[0], {1'b0, 2'b11, 32'h000B000A});
    check("bp_b1", beat_log[1], {1'b0, 2'b11, 32'h000D000C});
    check("bp_b2", beat_log[2], {1'b0, 2'b11, 32'h000F000E});
    wait_idle("bp_idle");

    // Flush partial
    beat_log.delete();
    push(16'h00AB);
    tick(4);
    pulse_flush();
    cnt_a = 0;
    repeat (10) begin if (flush_done) cnt_a++; tick(1); end
    check("flush_part_beats", beat_log.size(), 1);
    check("flush_part_beat", beat_log[0], {1'b1, 2'b01, 32'h000000AB});
    check("flush_part_done", cnt_a, 1);
    wait_idle("flush_part_idle");

    // Flush when empty
    beat_log.delete();
    pulse_flush();
    cnt_a = 0; cnt_b = 0;
    repeat (8) begin if (flush_done) cnt_a++; if (busy) cnt_b++; tick(1); end
    check("flush_empty_done", cnt_a, 1);
    check("flush_empty_busy", cnt_b, 0);
    check("flush_empty_beats", beat_log.size(), 0);

    // Empty guard and underflow
    cnt_a = 0;
    fifo_underflow = 1'b1;
    repeat (3) begin #1; if (fifo_rd_en) cnt_a++; tick(1); end
    fifo_underflow = 1'b0;
    repeat (3) begin #1; if (fifo_rd_en) cnt_a++; tick(1); end
    check("empty_no_read", cnt_a, 0);
    check("err_cnt", err_cnt, 8'd3);

    // Reset mid-beat: one word packed, one read pending
    beat_log.delete();
    push(16'h0011);
    push(16'h0022);
    tick(2);
    #1 rst = 1'b1;
    #1 check("reset_mid_outputs",
             {fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done, busy, err_cnt}, '0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_no_stale", m_valid, 0);
    push(16'h0033);
    push(16'h0044);
    wait_beats("reset_timeout", 1);
    check("reset_post_beat", beat_log[0], {1'b0, 2'b11, 32'h00440033});
    wait_idle("reset_idle");

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain_packer.md
# fifo_drain_packer

Read-side drain stage directly downstream of the synchronous FIFO. Issues FIFO reads whenever data is available and it has room, absorbs the FIFO's one-cycle registered read latency, packs PACK consecutive FIFO words into one wide beat, and presents that beat on a valid/ready stream. A flush request emits any partially packed beat with a lane-keep mask.

## Interface
- FIFO_WIDTH, 16: width of one FIFO word.
- PACK, 2: FIFO words per output beat; legal values are 2..8.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag.
- m_data  out  FIFO_WIDTH*PACK  packed beat; the first word read occupies lane 0 (LSBs).
- m_keep  out  PACK  per-lane valid mask.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  marks a beat emitted by a flush.
- flush  in  1  single-cycle flush request.
- flush_done  out  1  single-cycle pulse when the flush completes.
- busy  out  1  high when any word is in flight, being packed, or held.
- err_cnt  out  8  saturating count of cycles with fifo_underflow=1.

## Operation
- States:
  - PACK: normal packing.
  - FLUSH: no new reads; wait until rd_pend=0, then emit.
  - EMIT: wait for the output slot to drain, then pulse flush_done.
- Internal registers:
  - asm_data / asm_cnt (0..PACK) form the assembly register.
  - rd_pend is 1 when a read issued last cycle has data arriving this cycle.
  - out_data / out_valid form the output holding slot.
- fifo_rd_en = state==PACK && !fifo_empty && (asm_cnt + rd_pend < PACK). The block never reads an empty FIFO.
- When rd_pend=1, fifo_data_out is written into lane asm_cnt and asm_cnt increments.
- When asm_cnt==PACK and the slot is free (!out_valid, or m_valid&&m_ready this cycle):
  - move asm_data to the slot with m_keep all ones and m_last=0;
  - set asm_cnt to 0.
- The slot holds m_data, m_keep and m_last stable while m_valid && !m_ready.
- Flush:
  - flush is sampled only in PACK (ignored elsewhere); go to FLUSH.
  - Once rd_pend=0 and the slot is free:
    - if asm_cnt>0, load the slot with asm_data, unused lanes zeroed, m_keep = (1<<asm_cnt)-1, m_last=1, then go to EMIT;
    - if asm_cnt==0, pulse flush_done and return to PACK.
  - EMIT pulses flush_done in the cycle after the m_last beat is accepted, then returns to PACK.
  - A full beat already in the slot drains normally before the partial beat.
- A flush arriving in the same cycle as a read issue: that read still completes and is included in the flush.
- err_cnt saturates at 255 and is cleared only by reset.
- busy = rd_pend || asm_cnt!=0 || out_valid || state!=PACK.

## Timing
- Reset values (asynchronous, immediate): fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0, err_cnt=0, busy=0, state=PACK.
- Reset mid-operation discards all in-flight and packed words. No stale beat may appear after reset deasserts.
- Latency: a read at edge t returns data at edge t+1. The beat completing at t+1 is written to the slot at edge t+2 and is visible on m_valid after t+2.
- Handshake: a beat transfers on the edge where m_valid && m_ready. m_valid never drops without a transfer.
- Back-pressure: with m_ready=0 indefinitely, at most PACK words sit in assembly plus one beat in the slot. Reads then stop and no word is lost or duplicated.
- Word ordering is strict FIFO order across beat boundaries and wrap-around.

## Structure
- Package fifo_drain_pkg holds:
  - FIFO_WIDTH_DEF=16 and PACK_DEF=2;
  - the state enum (PACK, FLUSH, EMIT);
  - the function keep_mask(cnt).
- Sub-module fifo_drain_obuf is the output holding slot with the valid/ready hold logic. Everything else stays in the top module.

## Test plan
- Streaming: FIFO preloaded with 0x0001..0x0008, m_ready=1 → beats 0x00020001, 0x00040003, 0x00060005, 0x00080007, all with m_keep=2'b11 and m_last=0.
- Back-pressure: 0x000A..0x000F preloaded, m_ready=0 for 20 cycles.
  - Required: m_valid holds 0x000B000A stable.
  - Reads stop after four words have been issued.
  - Releasing m_ready yields 0x000D000C, then 0x000F000E.
- Flush partial: single word 0x00AB, then flush → beat 0x000000AB with m_keep=2'b01 and m_last=1; flush_done pulses in the cycle after acceptance.
- Flush when empty: flush with no data → no beat; flush_done pulses; busy stays 0.
- Empty guard and underflow: FIFO empty throughout, fifo_underflow forced high for 3 cycles → fifo_rd_en never asserts; err_cnt=3.
- Reset mid-beat: assert rst with one word packed and one read pending → all outputs are 0 immediately; after release, the next beat contains only post-reset words.
